// File: rtl/imm_gen_pkg.sv
// Shared types for the decode-stage immediate generator: format select,
// supported XLEN values and the buffered entry record.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_J = 3'd3,
      IMM_U = 3'd4,
      IMM_Z = 3'd5
   } imm_src_e;

   localparam int XLEN_32   = 32;
   localparam int XLEN_64   = 64;
   localparam int IMM_MAX_W = XLEN_64;
   localparam int TAG_MAX_W = 16;

   // Sized for the widest configuration; narrower builds leave upper bits zero.
   typedef struct packed {
      logic [IMM_MAX_W-1:0] imm;
      logic [TAG_MAX_W-1:0] tag;
      logic                 illegal;
   } entry_t;

endpackage

// File: rtl/imm_format.sv
// Combinational RISC-V immediate extraction: instruction + format select ->
// XLEN-wide immediate and an illegal-format flag.
module imm_format
   import imm_gen_pkg::*;
#(
   parameter int XLEN = XLEN_32
) (
   input  logic [31:0]     i_instruction,
   input  logic [2:0]      i_imm_src,
   output logic [XLEN-1:0] o_immediate,
   output logic            o_illegal
);

   logic [31:0] w_raw;
   logic        w_unused_opcode;

   assign w_unused_opcode = ^i_instruction[6:0];

   // Every format is first built sign-extended to 32 bits (zimm has a zero top bit).
   always_comb begin
      w_raw     = 32'd0;
      o_illegal = 1'b0;
      case (i_imm_src)
         IMM_I:   w_raw = {{20{i_instruction[31]}}, i_instruction[31:20]};
         IMM_S:   w_raw = {{20{i_instruction[31]}}, i_instruction[31:25],
                           i_instruction[11:7]};
         IMM_B:   w_raw = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                           i_instruction[30:25], i_instruction[11:8], 1'b0};
         IMM_J:   w_raw = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                           i_instruction[20], i_instruction[30:21], 1'b0};
         IMM_U:   w_raw = {i_instruction[31:12], 12'd0};
         IMM_Z:   w_raw = {27'd0, i_instruction[19:15]};
         default: begin
            w_raw     = 32'd0;
            o_illegal = 1'b1;
         end
      endcase
   end

   assign o_immediate = XLEN'($signed(w_raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer on a valid/ready
// handshake. Optional macro IMM_GEN_ERR_CNT_EN adds a saturating illegal-entry counter.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = XLEN_32,
   parameter int TAG_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [31:0]      i_instruction,
   input  logic [2:0]       i_imm_src,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [XLEN-1:0]  o_immediate,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_illegal
`ifdef IMM_GEN_ERR_CNT_EN
   ,
   output logic [15:0]      o_err_cnt
`endif
);

   logic [XLEN-1:0] w_imm;
   logic            w_illegal;
   logic            w_in_xfer;
   logic            w_out_xfer;
   logic            w_unused_hi;
   entry_t          w_in;
   entry_t          r_out;
   entry_t          r_skid;
   logic            r_out_valid;
   logic            r_skid_valid;

   imm_format #(.XLEN(XLEN)) u_format (
      .i_instruction (i_instruction),
      .i_imm_src     (i_imm_src),
      .o_immediate   (w_imm),
      .o_illegal     (w_illegal)
   );

   assign w_in_xfer  = i_valid & ~r_skid_valid;
   assign w_out_xfer = r_out_valid & i_ready;

   // Pack the incoming immediate and tag into a full-width entry record.
   always_comb begin
      w_in         = '0;
      w_in.imm     = IMM_MAX_W'(w_imm);
      w_in.tag     = TAG_MAX_W'(i_tag);
      w_in.illegal = w_illegal;
   end

   // Output/skid registers; the skid only fills when the output is stalled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_out        <= '0;
         r_skid       <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (i_flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (r_skid_valid) begin
         if (w_out_xfer) begin
            r_out        <= r_skid;
            r_skid_valid <= 1'b0;
         end
      end else if (w_in_xfer) begin
         if (!r_out_valid || w_out_xfer) begin
            r_out       <= w_in;
            r_out_valid <= 1'b1;
         end else begin
            r_skid       <= w_in;
            r_skid_valid <= 1'b1;
         end
      end else if (w_out_xfer) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef IMM_GEN_ERR_CNT_EN
   logic [15:0] r_err_cnt;

   // Count illegal entries actually accepted; a flushed input was never accepted.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_err_cnt <= 16'd0;
      end else if (w_in_xfer && !i_flush && w_illegal && (r_err_cnt != 16'hFFFF)) begin
         r_err_cnt <= r_err_cnt + 16'd1;
      end else begin
         r_err_cnt <= r_err_cnt;
      end
   end

   assign o_err_cnt = r_err_cnt;
`endif

   assign w_unused_hi = ^{r_out.imm, r_out.tag};

   assign o_ready     = ~r_skid_valid;
   assign o_valid     = r_out_valid;
   assign o_immediate = r_out.imm[XLEN-1:0];
   assign o_tag       = r_out.tag[TAG_W-1:0];
   assign o_illegal   = r_out.illegal;

endmodule
